// File: rtl/instr_loader.sv
// Instruction program loader: packs {op, A, B} words into a program memory
// over valid/ready, appends an all-zero terminator on seal, and serves reads.
module instr_loader #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned OPW   = 3,
  parameter int unsigned DW    = 8,
  localparam int unsigned IW   = OPW + 2 * DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [DW-1:0]  in_a,
  input  logic [DW-1:0]  in_b,
  input  logic          seal,
  input  logic          clear,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] rd_data,
  output logic [AW:0]   prog_len,
  output logic          full,
  output logic          sealed,
  output logic          err
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    TERM   = 2'd1,
    SEALED = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] wr_ptr;
  logic          accept;
  logic [IW-1:0] mem [DEPTH];

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  assign full     = (wr_ptr == LAST);
  assign in_ready = (state == LOAD) && !full;
  assign accept   = in_valid && in_ready;
  assign prog_len = {1'b0, wr_ptr};
  assign sealed   = (state == SEALED);

  always_comb begin
    state_next = state;
    unique case (state)
      LOAD:    if (seal) state_next = TERM;
      TERM:    state_next = SEALED;
      SEALED:  state_next = SEALED;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LOAD;
      wr_ptr  <= '0;
      err     <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      if (clear) begin
        state  <= LOAD;
        wr_ptr <= '0;
        err    <= 1'b0;
      end else begin
        state <= state_next;
        if (accept) wr_ptr <= wr_ptr + 1'b1;
        if (in_valid && (state != LOAD)) err <= 1'b1;
      end
    end
  end

  // Memory has no reset; reset and clear both suppress any write on their edge,
  // which is what aborts a pending terminator.
  always_ff @(posedge clk) begin
    if (!reset && !clear) begin
      if (accept)
        mem[wr_ptr] <= {in_op, in_a, in_b};
      else if (state == TERM)
        mem[wr_ptr] <= '0;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: encoding, full/backpressure, seal+accept,
// error flag, clear/reset mid-operation and read-during-write.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset, in_valid, seal, clear;
  logic        in_ready, full, sealed, err;
  logic [2:0]  in_op;
  logic [7:0]  in_a, in_b;
  logic [5:0]  rd_addr;
  logic [18:0] rd_data;
  logic [6:0]  prog_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_loader #(.DEPTH(64), .AW(6), .OPW(3), .DW(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .seal(seal), .clear(clear),
    .rd_addr(rd_addr), .rd_data(rd_data), .prog_len(prog_len),
    .full(full), .sealed(sealed), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic read_mem(input logic [5:0] addr, output logic [18:0] data);
    rd_addr = addr;
    tick();
    data = rd_data;
  endtask

  task automatic seal_pulse();
    seal = 1'b1;
    tick();
    seal = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, full, sealed, err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags got rdy/full/sealed/err=%b want 1000", {in_ready, full, sealed, err});
    end
    checks++;
    if (prog_len !== 7'd0 || rd_data !== 19'h0) begin
      errors++;
      $display("FAIL reset_vals got prog_len=%0d rd_data=%h want 0 0", prog_len, rd_data);
    end
  endtask

  task automatic test_encode();
    logic [18:0] d;
    do_reset();
    push(3'd0, 8'h17, 8'h13);
    push(3'd1, 8'h03, 8'h4C);
    seal_pulse();
    checks++;
    if (sealed !== 1'b1 || prog_len !== 7'd2) begin
      errors++;
      $display("FAIL encode_seal got sealed=%b prog_len=%0d want 1 2", sealed, prog_len);
    end
    read_mem(6'd0, d);
    checks++;
    if (d !== 19'h01713) begin errors++; $display("FAIL encode_mem0 got %h want 01713", d); end
    read_mem(6'd1, d);
    checks++;
    if (d !== 19'h1034C) begin errors++; $display("FAIL encode_mem1 got %h want 1034C", d); end
    read_mem(6'd2, d);
    checks++;
    if (d !== 19'h00000) begin errors++; $display("FAIL encode_term got %h want 00000", d); end
  endtask

  task automatic test_full();
    int xfers = 0;
    logic [18:0] d;
    do_reset();
    in_valid = 1'b1; in_op = 3'd7; in_a = 8'h5D; in_b = 8'h52;
    for (int i = 0; i < 70; i++) begin
      if (in_ready) xfers++;
      tick();
    end
    checks++;
    if (xfers !== 63) begin errors++; $display("FAIL full_xfers got %0d want 63", xfers); end
    checks++;
    if ({in_ready, full, err} !== 3'b010 || prog_len !== 7'd63) begin
      errors++;
      $display("FAIL full_state got rdy/full/err=%b prog_len=%0d want 010 63", {in_ready, full, err}, prog_len);
    end
    in_valid = 1'b0;
    seal_pulse();
    read_mem(6'd63, d);
    checks++;
    if (d !== 19'h00000) begin errors++; $display("FAIL full_term got %h want 00000", d); end
    read_mem(6'd62, d);
    checks++;
    if (d !== 19'h75D52) begin errors++; $display("FAIL full_last got %h want 75D52", d); end
  endtask

  task automatic test_seal_accept();
    logic [18:0] d;
    do_reset();
    seal = 1'b1;
    push(3'd2, 8'h1F, 8'h05);
    seal = 1'b0;
    tick();
    read_mem(6'd0, d);
    checks++;
    if (d !== 19'h21F05) begin errors++; $display("FAIL sa_mem0 got %h want 21F05", d); end
    read_mem(6'd1, d);
    checks++;
    if (d !== 19'h00000) begin errors++; $display("FAIL sa_term got %h want 00000", d); end
    checks++;
    if (prog_len !== 7'd1 || sealed !== 1'b1) begin
      errors++;
      $display("FAIL sa_len got prog_len=%0d sealed=%b want 1 1", prog_len, sealed);
    end
  endtask

  task automatic test_error();
    logic [18:0] d;
    push(3'd6, 8'hAA, 8'h55);
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b0 || prog_len !== 7'd1) begin
      errors++;
      $display("FAIL err_set got err=%b rdy=%b prog_len=%0d want 1 0 1", err, in_ready, prog_len);
    end
    read_mem(6'd1, d);
    checks++;
    if (d !== 19'h00000) begin errors++; $display("FAIL err_mem1 got %h want 00000", d); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if ({err, sealed, in_ready} !== 3'b001 || prog_len !== 7'd0) begin
      errors++;
      $display("FAIL err_clear got err/sealed/rdy=%b prog_len=%0d want 001 0", {err, sealed, in_ready}, prog_len);
    end
  endtask

  task automatic test_clear_reset();
    logic [18:0] d;
    push(3'd1, 8'h11, 8'h22);
    push(3'd2, 8'h33, 8'h44);
    push(3'd3, 8'h55, 8'h66);
    seal = 1'b1;
    tick();
    seal = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    checks++;
    if (prog_len !== 7'd0 || sealed !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_term got prog_len=%0d sealed=%b rdy=%b want 0 0 1", prog_len, sealed, in_ready);
    end
    read_mem(6'd3, d);
    checks++;
    if (d !== 19'h75D52) begin errors++; $display("FAIL clr_mem3 got %h want 75D52", d); end
    reset = 1'b1;
    push(3'd4, 8'hAA, 8'hBB);
    reset = 1'b0;
    checks++;
    if (prog_len !== 7'd0 || rd_data !== 19'h0 || {in_ready, full, sealed, err} !== 4'b1000) begin
      errors++;
      $display("FAIL rst_valid got prog_len=%0d rd_data=%h flags=%b want 0 0 1000", prog_len, rd_data, {in_ready, full, sealed, err});
    end
    read_mem(6'd0, d);
    checks++;
    if (d !== 19'h11122) begin errors++; $display("FAIL rst_mem0 got %h want 11122", d); end
  endtask

  task automatic test_rdw();
    do_reset();
    push(3'd0, 8'h17, 8'h13);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    rd_addr = 6'd0;
    push(3'd4, 8'h5D, 8'h52);
    checks++;
    if (rd_data !== 19'h01713) begin errors++; $display("FAIL rdw_old got %h want 01713", rd_data); end
    tick();
    checks++;
    if (rd_data !== 19'h45D52) begin errors++; $display("FAIL rdw_new got %h want 45D52", rd_data); end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; seal = 1'b0; clear = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; rd_addr = '0;
    test_reset();
    test_encode();
    test_full();
    test_seal_accept();
    test_error();
    test_clear_reset();
    test_rdw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
